// File: rtl/control_unit_if.sv
// control_unit_if -- opcode-in / control-out bundle of the main decoder.
//   instruction : opcode field instr[6:0] of the current instruction
//   Branch      : conditional-branch instruction
//   MemRead     : data-memory read enable
//   MemtoReg    : write-back source (1 = memory data, 0 = ALU result)
//   ALUSrc      : ALU operand B source (1 = immediate, 0 = rs2)
//   MemWrite    : data-memory write enable
//   RegWrite    : register-file write enable
//   ALUOp       : ALU-control class (00 add, 01 sub/compare, 10 funct-decoded)
//   illegal_op  : sticky flag, set once an unsupported opcode was sampled
// master drives the opcode and observes the controls; slave is the decoder.
interface control_unit_if;
    logic [6:0] instruction;
    logic       Branch;
    logic       MemRead;
    logic       MemtoReg;
    logic       ALUSrc;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       illegal_op;

    modport master (
        output instruction,
        input  Branch, MemRead, MemtoReg, ALUSrc, MemWrite, RegWrite, ALUOp,
        input  illegal_op
    );

    modport slave (
        input  instruction,
        output Branch, MemRead, MemtoReg, ALUSrc, MemWrite, RegWrite, ALUOp,
        output illegal_op
    );
endinterface

// File: rtl/control_unit.sv
// control_unit -- main instruction decoder for a single-cycle RV32-style core.
//   clk   : rising-edge clock (only used by the illegal_op flag)
//   reset : synchronous, active-high; clears illegal_op only
//   bus   : control_unit_if.slave -- opcode in, decoded controls and the
//           sticky illegal_op flag out
// Control outputs are purely combinational from the opcode; any opcode
// outside the four supported ones decodes to all zeros.
module control_unit (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.slave bus
);

    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    logic legal;

    // Don't-care positions are tied to 0 through the defaults so nothing
    // ever leaves the block as X for a known opcode.
    always_comb begin
        bus.ALUSrc   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Branch   = 1'b0;
        bus.ALUOp    = 2'b00;
        legal        = 1'b1;
        case (bus.instruction)
            OP_RTYPE: begin
                bus.RegWrite = 1'b1;
                bus.ALUOp    = 2'b10;
            end
            OP_LOAD: begin
                bus.ALUSrc   = 1'b1;
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                bus.MemRead  = 1'b1;
            end
            OP_STORE: begin
                bus.ALUSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            OP_BRANCH: begin
                bus.Branch   = 1'b1;
                bus.ALUOp    = 2'b01;
            end
            default: legal = 1'b0;
        endcase
    end

    // Sticky until reset; reset wins over an illegal opcode on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.illegal_op <= 1'b0;
        end else if (!legal) begin
            bus.illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
// The expected decode comes from a lookup table keyed by opcode; the
// illegal_op expectation is a one-bit sticky model updated at each edge.
module tb_control_unit;

    logic clk;
    logic reset;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    logic [7:0] dec_tab [int];
    logic [6:0] legal_ops [4];
    logic       model_ill;

    function automatic logic [7:0] exp_ctrl(input logic [6:0] op);
        if (dec_tab.exists(int'(op))) return dec_tab[int'(op)];
        return 8'h00;
    endfunction

    function automatic logic [7:0] obs_ctrl();
        return {bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
                bus.MemWrite, bus.Branch, bus.ALUOp};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Updates the sticky model from the inputs sampled at the coming edge,
    // then moves to 1 time unit past that edge.
    task automatic tick();
        if (reset) model_ill = 1'b0;
        else if (!dec_tab.exists(int'(bus.instruction))) model_ill = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [6:0] op, input string tag);
        bus.instruction = op;
        #1;
        check(tag, obs_ctrl(), exp_ctrl(op));
    endtask

    initial begin
        logic [6:0] op;
        logic [7:0] mm;

        dec_tab[7'b0110011] = 8'b0010_0010;
        dec_tab[7'b0000011] = 8'b1111_0000;
        dec_tab[7'b0100011] = 8'b1000_1000;
        dec_tab[7'b1100011] = 8'b0000_0101;
        legal_ops[0] = 7'b0110011;
        legal_ops[1] = 7'b0000011;
        legal_ops[2] = 7'b0100011;
        legal_ops[3] = 7'b1100011;
        model_ill = 1'b0;

        // Directed decode checks, also while reset is held
        reset = 1'b1;
        apply(7'b0110011, "rtype");
        check("rtype_const", obs_ctrl(), 8'b0010_0010);
        tick();
        check("reset_ill", {7'b0, bus.illegal_op}, 8'h00);
        apply(7'b0000011, "load");
        check("load_const", obs_ctrl(), 8'b1111_0000);
        reset = 1'b0;
        tick();
        check("ill_after_load", {7'b0, bus.illegal_op}, {7'b0, model_ill});
        apply(7'b0100011, "store");
        check("store_const", obs_ctrl(), 8'b1000_1000);
        tick();
        check("ill_after_store", {7'b0, bus.illegal_op}, 8'h00);
        apply(7'b1100011, "branch");
        check("branch_const", obs_ctrl(), 8'b0000_0101);
        tick();
        check("ill_after_branch", {7'b0, bus.illegal_op}, 8'h00);
        apply(7'b1111111, "ones");
        check("ones_const", obs_ctrl(), 8'h00);
        tick();
        check("ill_set", {7'b0, bus.illegal_op}, 8'h01);
        apply(7'b0110011, "rtype_again");
        tick();
        check("ill_sticky", {7'b0, bus.illegal_op}, 8'h01);
        reset = 1'b1;
        tick();
        check("ill_cleared", {7'b0, bus.illegal_op}, 8'h00);

        // Reset and an illegal opcode on the same edge
        apply(7'b1111111, "reset_ones");
        tick();
        check("reset_wins", {7'b0, bus.illegal_op}, 8'h00);
        reset = 1'b0;

        // Exhaustive opcode sweep
        for (int i = 0; i < 128; i++) begin
            op = 7'(i);
            apply(op, "sweep");
            mm = {7'b0, bus.MemRead & bus.MemWrite};
            check("sweep_rdwr", mm, 8'h00);
            tick();
            check("sweep_ill", {7'b0, bus.illegal_op}, {7'b0, model_ill});
        end

        // Randomized opcodes and resets against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1, 0) == 1) op = legal_ops[$urandom_range(3, 0)];
            else op = 7'($urandom);
            reset = ($urandom_range(7, 0) == 0);
            apply(op, "rand");
            tick();
            check("rand_ill", {7'b0, bus.illegal_op}, {7'b0, model_ill});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
